// File: rtl/vga_timing_gen_if.sv
`default_nettype none
//==============================================================================
// Module   : vga_timing_gen_if
// Brief    : Raster timing bundle carried from the VGA timing generator to the
//            overlay checkers and colour mux (coordinates, enable, syncs,
//            pixel/line/frame strobes).
// Revision : 1.0 - initial release
//==============================================================================
interface vga_timing_gen_if #(
  parameter int PX_W = 10,
  parameter int PY_W = 9
);
  logic [PX_W-1:0] px;
  logic [PY_W-1:0] py;
  logic            en;
  logic            hsync;
  logic            vsync;
  logic            pix_tick;
  logic            line_start;
  logic            frame_start;

  modport master (
    output px, py, en, hsync, vsync, pix_tick, line_start, frame_start
  );

  modport slave (
    input  px, py, en, hsync, vsync, pix_tick, line_start, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
//==============================================================================
// Module   : vga_timing_gen
// Brief    : Raster timing source. A clock divider produces the pixel tick;
//            horizontal/vertical counters walk the raster and every output is a
//            registered decode of (div, h, v). Syncs are active low and can be
//            delayed by whole pixels to line up with a registered pixel stage.
// Revision : 1.0 - initial release
//==============================================================================
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int CLK_DIV    = 2,
  parameter int SYNC_DELAY = 1
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga_o
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PX_W     = $clog2(H_VISIBLE);
  localparam int PY_W     = $clog2(V_VISIBLE);
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  generate
    if (CLK_DIV < 1 || SYNC_DELAY > 4) begin : g_param_check
      $error("vga_timing_gen: CLK_DIV must be >= 1 and SYNC_DELAY must be <= 4");
    end
  endgenerate

  // Raster state
  logic [DW-1:0] div_q;
  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;

  // Combinational decodes of the current raster state
  logic            tick_d;
  logic            h_last_d;
  logic            v_last_d;
  logic            en_d;
  logic [PX_W-1:0] px_d;
  logic [PY_W-1:0] py_d;
  logic            hs_raw_d;
  logic            vs_raw_d;
  logic            hs_dly_d;
  logic            vs_dly_d;
  logic            line_start_d;
  logic            frame_start_d;

  // Registered outputs
  logic [PX_W-1:0] px_q;
  logic [PY_W-1:0] py_q;
  logic            en_q;
  logic            hsync_q;
  logic            vsync_q;
  logic            pix_tick_q;
  logic            line_start_q;
  logic            frame_start_q;

  // With CLK_DIV=1 div_q is stuck at 0, so the tick is permanently high.
  assign tick_d   = (div_q == DW'(CLK_DIV - 1));
  assign h_last_d = (h_q == HW'(H_TOTAL - 1));
  assign v_last_d = (v_q == VW'(V_TOTAL - 1));

  // Divider runs every clk; h/v only move on the pixel tick, v only on the h wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= tick_d ? '0 : div_q + DW'(1);
      if (tick_d) begin
        if (h_last_d) begin
          h_q <= '0;
          v_q <= v_last_d ? '0 : v_q + VW'(1);
        end else begin
          h_q <= h_q + HW'(1);
        end
      end
    end
  end

  assign en_d          = (h_q < HW'(H_VISIBLE)) && (v_q < VW'(V_VISIBLE));
  assign px_d          = en_d ? h_q[PX_W-1:0] : '0;
  assign py_d          = en_d ? v_q[PY_W-1:0] : '0;
  assign hs_raw_d      = !((h_q >= HW'(HS_START)) && (h_q < HW'(HS_END)));
  assign vs_raw_d      = !((v_q >= VW'(VS_START)) && (v_q < VW'(VS_END)));
  assign line_start_d  = tick_d && (h_q == '0);
  assign frame_start_d = line_start_d && (v_q == '0);

  generate
    if (SYNC_DELAY == 0) begin : g_sync_bypass
      assign hs_dly_d = hs_raw_d;
      assign vs_dly_d = vs_raw_d;
    end else begin : g_sync_delay
      logic [SYNC_DELAY-1:0] hs_sr_q;
      logic [SYNC_DELAY-1:0] vs_sr_q;

      // Sync pipeline advances on pixel ticks so the delay is counted in pixels;
      // reset loads idle-high so no stale pulse survives a reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          hs_sr_q <= '1;
          vs_sr_q <= '1;
        end else if (tick_d) begin
          hs_sr_q[0] <= hs_raw_d;
          vs_sr_q[0] <= vs_raw_d;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_sr_q[i] <= hs_sr_q[i-1];
            vs_sr_q[i] <= vs_sr_q[i-1];
          end
        end
      end

      assign hs_dly_d = hs_sr_q[SYNC_DELAY-1];
      assign vs_dly_d = vs_sr_q[SYNC_DELAY-1];
    end
  endgenerate

  // One output register stage gives a fixed single-clk latency for every CLK_DIV.
  always_ff @(posedge clk) begin
    if (rst) begin
      px_q          <= '0;
      py_q          <= '0;
      en_q          <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      px_q          <= px_d;
      py_q          <= py_d;
      en_q          <= en_d;
      hsync_q       <= hs_dly_d;
      vsync_q       <= vs_dly_d;
      pix_tick_q    <= tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_o.px          = px_q;
  assign vga_o.py          = py_q;
  assign vga_o.en          = en_q;
  assign vga_o.hsync       = hsync_q;
  assign vga_o.vsync       = vsync_q;
  assign vga_o.pix_tick    = pix_tick_q;
  assign vga_o.line_start  = line_start_q;
  assign vga_o.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
//==============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Self-checking bench. Three generators share one clock: A uses the
//            default 640x480 timing, B a tiny raster with CLK_DIV=3 and
//            SYNC_DELAY=2, C the default line with CLK_DIV=1, SYNC_DELAY=0 and
//            a short frame. A reference model predicts every output per clk.
// Revision : 1.0 - initial release
//==============================================================================
module tb_vga_timing_gen;

  typedef struct packed {
    logic [15:0] px;
    logic [15:0] py;
    logic        en;
    logic        hs;
    logic        vs;
    logic        pt;
    logic        ls;
    logic        fs;
  } rec_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.PX_W(10), .PY_W(9)) if_a ();
  vga_timing_gen_if #(.PX_W(4),  .PY_W(3)) if_b ();
  vga_timing_gen_if #(.PX_W(10), .PY_W(2)) if_c ();

  vga_timing_gen #(
    .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(480), .V_FRONT(10), .V_SYNC(2),  .V_BACK(33),
    .CLK_DIV(2), .SYNC_DELAY(1)
  ) dut_a (.clk(clk), .rst(rst_a), .vga_o(if_a));

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .CLK_DIV(3), .SYNC_DELAY(2)
  ) dut_b (.clk(clk), .rst(rst_b), .vga_o(if_b));

  vga_timing_gen #(
    .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(4),   .V_FRONT(1),  .V_SYNC(1),  .V_BACK(1),
    .CLK_DIV(1), .SYNC_DELAY(0)
  ) dut_c (.clk(clk), .rst(rst_c), .vga_o(if_c));

  rec_t o_a, o_b, o_c;
  assign o_a = {6'd0,  if_a.px, 7'd0,  if_a.py, if_a.en, if_a.hsync, if_a.vsync,
                if_a.pix_tick, if_a.line_start, if_a.frame_start};
  assign o_b = {12'd0, if_b.px, 13'd0, if_b.py, if_b.en, if_b.hsync, if_b.vsync,
                if_b.pix_tick, if_b.line_start, if_b.frame_start};
  assign o_c = {6'd0,  if_c.px, 14'd0, if_c.py, if_c.en, if_c.hsync, if_c.vsync,
                if_c.pix_tick, if_c.line_start, if_c.frame_start};

  rec_t q_a[$], q_b[$], q_c[$];
  int   n_a = 0, n_b = 0, n_c = 0;
  int   vectors = 0;
  int   miscompares = 0;

  // Expected outputs after a clk, from clks elapsed since reset release.
  function automatic rec_t model(input bit in_rst, input int n, input int cdiv, input int sd,
                                 input int hv, input int hf, input int hsw, input int hb,
                                 input int vv, input int vf, input int vsw, input int vb);
    rec_t r;
    int htot, vtot, p, h, v, pd, hd, vd;
    bit tick;
    r    = '0;
    r.hs = 1'b1;
    r.vs = 1'b1;
    if (in_rst) return r;
    htot = hv + hf + hsw + hb;
    vtot = vv + vf + vsw + vb;
    p    = n / cdiv;
    h    = p % htot;
    v    = (p / htot) % vtot;
    tick = ((n % cdiv) == cdiv - 1);
    r.en = (h < hv) && (v < vv);
    if (r.en) begin
      r.px = 16'(h);
      r.py = 16'(v);
    end
    pd = p - sd;
    if (pd >= 0) begin
      hd   = pd % htot;
      vd   = (pd / htot) % vtot;
      r.hs = !((hd >= hv + hf) && (hd < hv + hf + hsw));
      r.vs = !((vd >= vv + vf) && (vd < vv + vf + vsw));
    end
    r.pt = tick;
    r.ls = tick && (h == 0);
    r.fs = r.ls && (v == 0);
    return r;
  endfunction

  // Drive resets for one clk and queue what each DUT must show after that edge.
  task automatic step(input bit ra, input bit rb, input bit rc);
    rst_a = ra;
    rst_b = rb;
    rst_c = rc;
    @(posedge clk);
    q_a.push_back(model(ra, n_a, 2, 1, 640, 16, 96, 48, 480, 10, 2, 33));
    q_b.push_back(model(rb, n_b, 3, 2, 16, 2, 4, 3, 8, 2, 2, 3));
    q_c.push_back(model(rc, n_c, 1, 0, 640, 16, 96, 48, 4, 1, 1, 1));
    n_a = ra ? 0 : n_a + 1;
    n_b = rb ? 0 : n_b + 1;
    n_c = rc ? 0 : n_c + 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rec_t ea, eb, ec;
    bit ra, rbc;
    for (int i = 0; i < 3820; i++) begin
      ra  = (i < 3) || (i >= 3803 && i < 3808);
      rbc = (i < 3);
      step(ra, rbc, rbc);
      ea = q_a.pop_front(); eb = q_b.pop_front(); ec = q_c.pop_front(); vectors += 3;
      if (o_a !== ea) begin miscompares++; $display("FAIL reset_a cyc=%0d got=%p exp=%p", i, o_a, ea); end
      if (o_b !== eb) begin miscompares++; $display("FAIL reset_b cyc=%0d got=%p exp=%p", i, o_b, eb); end
      if (o_c !== ec) begin miscompares++; $display("FAIL reset_c cyc=%0d got=%p exp=%p", i, o_c, ec); end
      if (i == 3802) begin
        vectors++;
        if (if_a.en !== 1'b1 || if_a.px !== 10'd299 || if_a.py !== 9'd2) begin
          miscompares++;
          $display("FAIL pre_reset_pos got en=%b px=%0d py=%0d exp en=1 px=299 py=2", if_a.en, if_a.px, if_a.py);
        end
      end
      if (i == 3803) begin
        vectors++;
        if (if_a.en !== 1'b0 || if_a.px !== 10'd0 || if_a.hsync !== 1'b1 || if_a.vsync !== 1'b1 || if_a.pix_tick !== 1'b0) begin
          miscompares++;
          $display("FAIL mid_line_reset got en=%b px=%0d hs=%b vs=%b pt=%b exp 0 0 1 1 0",
                   if_a.en, if_a.px, if_a.hsync, if_a.vsync, if_a.pix_tick);
        end
      end
      if (i == 3808) begin
        vectors++;
        if (if_a.en !== 1'b1 || if_a.px !== 10'd0 || if_a.py !== 9'd0 || if_a.frame_start !== 1'b0) begin
          miscompares++;
          $display("FAIL release_clk1 got en=%b px=%0d py=%0d fs=%b exp en=1 px=0 py=0 fs=0",
                   if_a.en, if_a.px, if_a.py, if_a.frame_start);
        end
      end
      if (i == 3809) begin
        vectors++;
        if (if_a.frame_start !== 1'b1 || if_a.line_start !== 1'b1) begin
          miscompares++;
          $display("FAIL release_clk2_fs got fs=%b ls=%b exp fs=1 ls=1", if_a.frame_start, if_a.line_start);
        end
      end
    end
  endtask

  task automatic test_line_timing();
    rec_t ea, eb, ec;
    int t = 0, last_ls = 0, periods = 0;
    bit seen = 0, exp_en, exp_hs;
    for (int i = 0; i < 4810; i++) begin
      step(0, 0, 0);
      ea = q_a.pop_front(); eb = q_b.pop_front(); ec = q_c.pop_front(); vectors += 3;
      if (o_a !== ea) begin miscompares++; $display("FAIL line_a cyc=%0d got=%p exp=%p", i, o_a, ea); end
      if (o_b !== eb) begin miscompares++; $display("FAIL line_b cyc=%0d got=%p exp=%p", i, o_b, eb); end
      if (o_c !== ec) begin miscompares++; $display("FAIL line_c cyc=%0d got=%p exp=%p", i, o_c, ec); end
      if (if_a.pix_tick === 1'b1) begin
        if (if_a.line_start === 1'b1) begin
          if (seen) begin
            vectors++; periods++;
            if (i - last_ls != 1600) begin
              miscompares++;
              $display("FAIL line_period got=%0d exp=1600", i - last_ls);
            end
          end
          seen = 1; last_ls = i; t = 0;
        end else begin
          t++;
        end
        if (seen) begin
          exp_en = (t < 640);
          exp_hs = !(t >= 657 && t <= 752);
          vectors++;
          if (if_a.en !== exp_en || if_a.hsync !== exp_hs) begin
            miscompares++;
            $display("FAIL line_tick t=%0d got en=%b hs=%b exp en=%b hs=%b", t, if_a.en, if_a.hsync, exp_en, exp_hs);
          end
        end
      end
    end
    vectors++;
    if (periods < 2) begin miscompares++; $display("FAIL line_periods_seen got=%0d exp>=2", periods); end
  endtask

  task automatic test_frame_timing();
    rec_t ea, eb, ec;
    int lb = 0, tb_ = 0, last_b = 0, per_b = 0;
    int lc = 0, tc = 0, last_c = 0, per_c = 0;
    bit seen_b = 0, seen_c = 0, e_en, e_hs, e_vs;
    for (int i = 0; i < 11220; i++) begin
      step(0, 0, 0);
      ea = q_a.pop_front(); eb = q_b.pop_front(); ec = q_c.pop_front(); vectors += 3;
      if (o_a !== ea) begin miscompares++; $display("FAIL frame_a cyc=%0d got=%p exp=%p", i, o_a, ea); end
      if (o_b !== eb) begin miscompares++; $display("FAIL frame_b cyc=%0d got=%p exp=%p", i, o_b, eb); end
      if (o_c !== ec) begin miscompares++; $display("FAIL frame_c cyc=%0d got=%p exp=%p", i, o_c, ec); end
      vectors++;
      if (if_c.pix_tick !== 1'b1) begin miscompares++; $display("FAIL div1_tick cyc=%0d got=%b exp=1", i, if_c.pix_tick); end
      if (if_b.pix_tick === 1'b1) begin
        if (if_b.frame_start === 1'b1) begin
          if (seen_b) begin
            vectors++; per_b++;
            if (i - last_b != 1125 || lb != 14) begin
              miscompares++;
              $display("FAIL frame_period_b got clks=%0d lines=%0d exp clks=1125 lines=15", i - last_b, lb + 1);
            end
          end
          seen_b = 1; last_b = i; lb = 0; tb_ = 0;
        end else if (if_b.line_start === 1'b1) begin
          lb++; tb_ = 0;
        end else begin
          tb_++;
        end
        if (seen_b) begin
          e_en = (lb < 8) && (tb_ < 16);
          e_hs = !(tb_ >= 20 && tb_ <= 23);
          e_vs = !((lb * 25 + tb_) >= 252 && (lb * 25 + tb_) <= 301);
          vectors++;
          if (if_b.en !== e_en || if_b.hsync !== e_hs || if_b.vsync !== e_vs) begin
            miscompares++;
            $display("FAIL frame_b_pix l=%0d t=%0d got en=%b hs=%b vs=%b exp en=%b hs=%b vs=%b",
                     lb, tb_, if_b.en, if_b.hsync, if_b.vsync, e_en, e_hs, e_vs);
          end
        end
      end
      if (if_c.frame_start === 1'b1) begin
        if (seen_c) begin
          vectors++; per_c++;
          if (i - last_c != 5600 || lc != 6) begin
            miscompares++;
            $display("FAIL frame_period_c got clks=%0d lines=%0d exp clks=5600 lines=7", i - last_c, lc + 1);
          end
        end
        seen_c = 1; last_c = i; lc = 0; tc = 0;
      end else if (if_c.line_start === 1'b1) begin
        lc++; tc = 0;
      end else begin
        tc++;
      end
      if (seen_c) begin
        e_en = (lc < 4) && (tc < 640);
        e_hs = !(tc >= 656 && tc <= 751);
        e_vs = (lc != 5);
        vectors++;
        if (if_c.en !== e_en || if_c.hsync !== e_hs || if_c.vsync !== e_vs) begin
          miscompares++;
          $display("FAIL frame_c_pix l=%0d h=%0d got en=%b hs=%b vs=%b exp en=%b hs=%b vs=%b",
                   lc, tc, if_c.en, if_c.hsync, if_c.vsync, e_en, e_hs, e_vs);
        end
      end
    end
    vectors++;
    if (per_b < 1 || per_c < 1) begin
      miscompares++;
      $display("FAIL frame_periods_seen got b=%0d c=%0d exp>=1", per_b, per_c);
    end
  endtask

  task automatic test_coordinates();
    rec_t ea, eb, ec;
    bit pend = 0;
    int hits = 0, fs_hits = 0;
    for (int i = 0; i < 1200; i++) begin
      step(0, 0, 0);
      ea = q_a.pop_front(); eb = q_b.pop_front(); ec = q_c.pop_front(); vectors += 3;
      if (o_a !== ea) begin miscompares++; $display("FAIL coord_a cyc=%0d got=%p exp=%p", i, o_a, ea); end
      if (o_b !== eb) begin miscompares++; $display("FAIL coord_b cyc=%0d got=%p exp=%p", i, o_b, eb); end
      if (o_c !== ec) begin miscompares++; $display("FAIL coord_c cyc=%0d got=%p exp=%p", i, o_c, ec); end
      if (if_b.pix_tick === 1'b1) begin
        if (pend) begin
          pend = 0;
          vectors++;
          if (if_b.en !== 1'b0 || if_b.px !== 4'd0 || if_b.py !== 3'd0) begin
            miscompares++;
            $display("FAIL after_last_visible got en=%b px=%0d py=%0d exp 0 0 0", if_b.en, if_b.px, if_b.py);
          end
        end
        if (if_b.en === 1'b1 && if_b.px === 4'd15 && if_b.py === 3'd7) begin
          pend = 1; hits++;
        end
        if (if_b.frame_start === 1'b1) begin
          fs_hits++;
          vectors++;
          if (if_b.en !== 1'b1 || if_b.px !== 4'd0 || if_b.py !== 3'd0) begin
            miscompares++;
            $display("FAIL frame_start_origin got en=%b px=%0d py=%0d exp 1 0 0", if_b.en, if_b.px, if_b.py);
          end
        end
      end
    end
    vectors++;
    if (hits < 1 || fs_hits < 1) begin
      miscompares++;
      $display("FAIL coord_events got last_visible=%0d frame_start=%0d exp>=1", hits, fs_hits);
    end
  endtask

  task automatic test_sync_reset();
    rec_t ea, eb, ec;
    bit found = 0;
    int lo = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step(0, 0, 0);
      ea = q_a.pop_front(); eb = q_b.pop_front(); ec = q_c.pop_front(); vectors += 3;
      if (o_a !== ea) begin miscompares++; $display("FAIL vwait_a cyc=%0d got=%p exp=%p", i, o_a, ea); end
      if (o_b !== eb) begin miscompares++; $display("FAIL vwait_b cyc=%0d got=%p exp=%p", i, o_b, eb); end
      if (o_c !== ec) begin miscompares++; $display("FAIL vwait_c cyc=%0d got=%p exp=%p", i, o_c, ec); end
      if (if_b.vsync === 1'b0) found = 1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL vsync_wait got=no_pulse exp=vsync low within 2000 clks"); end
    step(0, 1, 0);
    ea = q_a.pop_front(); eb = q_b.pop_front(); ec = q_c.pop_front(); vectors += 4;
    if (o_a !== ea) begin miscompares++; $display("FAIL vrst_a got=%p exp=%p", o_a, ea); end
    if (o_b !== eb) begin miscompares++; $display("FAIL vrst_b got=%p exp=%p", o_b, eb); end
    if (o_c !== ec) begin miscompares++; $display("FAIL vrst_c got=%p exp=%p", o_c, ec); end
    if (if_b.vsync !== 1'b1 || if_b.hsync !== 1'b1 || if_b.en !== 1'b0) begin
      miscompares++;
      $display("FAIL vsync_reset got vs=%b hs=%b en=%b exp vs=1 hs=1 en=0", if_b.vsync, if_b.hsync, if_b.en);
    end
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 0);
      ea = q_a.pop_front(); eb = q_b.pop_front(); ec = q_c.pop_front(); vectors += 3;
      if (o_a !== ea) begin miscompares++; $display("FAIL flush_a cyc=%0d got=%p exp=%p", i, o_a, ea); end
      if (o_b !== eb) begin miscompares++; $display("FAIL flush_b cyc=%0d got=%p exp=%p", i, o_b, eb); end
      if (o_c !== ec) begin miscompares++; $display("FAIL flush_c cyc=%0d got=%p exp=%p", i, o_c, ec); end
      if (if_b.vsync !== 1'b1) lo++;
    end
    vectors++;
    if (lo != 0) begin miscompares++; $display("FAIL residual_vsync got=%0d low clks exp=0", lo); end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_coordinates();
    test_sync_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=bench completion");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
